// File: rtl/xxd_pkg.sv
// Shared definitions for the xxd hex-dump parser family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xxd_pkg;

    // Parser line state: offset field, hex high/low nibble, discard-to-newline
    typedef enum logic [1:0] {
        S_OFS    = 2'd0,
        S_HEX_HI = 2'd1,
        S_HEX_LO = 2'd2,
        S_SKIP   = 2'd3
    } state_t;

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_COLON = 8'h3A;

endpackage

// File: rtl/hex_nibble_decode.sv
// ASCII hex digit classifier/decoder ('0'-'9', 'a'-'f', 'A'-'F').
// Latency: combinational.
// Backpressure: none, pure function of the input character.
module hex_nibble_decode (
    input  logic [7:0] i_char,
    output logic       o_is_hex,
    output logic [3:0] o_nib
);

    // Digits map straight from the low nibble; letters a-f / A-F have low
    // nibble 1..6, so adding 9 yields 10..15.
    always_comb begin
        o_is_hex = 1'b0;
        o_nib    = 4'd0;
        if (i_char >= 8'h30 && i_char <= 8'h39) begin
            o_is_hex = 1'b1;
            o_nib    = i_char[3:0];
        end else if ((i_char >= 8'h41 && i_char <= 8'h46) ||
                     (i_char >= 8'h61 && i_char <= 8'h66)) begin
            o_is_hex = 1'b1;
            o_nib    = i_char[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/xxd_reverse.sv
// Streaming xxd text parser: one char per cycle in, address-tagged bytes out.
// Latency: a byte appears 1 cycle after its low nibble is accepted.
// Backpressure: in_ready = !out_valid || out_ready; input stalls while a byte is held.
module xxd_reverse
    import xxd_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int OFS_DIGITS_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_char,
    output logic              in_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              out_ready,
    output logic              line_done,
    output logic              err
);

    localparam int             CNT_W   = $clog2(OFS_DIGITS_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OFS_DIGITS_MAX);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [1:0]          r_spc;
    logic [3:0]          r_hi;
    logic [ADDR_W-1:0]   r_line_addr;
    logic                r_out_valid;
    logic [7:0]          r_out_data;
    logic [ADDR_W-1:0]   r_out_addr;
    logic                r_line_done;
    logic                r_err;

    logic                w_accept;
    logic                w_is_hex;
    logic [3:0]          w_nib;
    logic                w_is_lf;
    logic                w_is_cr;
    logic                w_is_sp;
    logic                w_is_colon;
    logic                w_cnt_full;
    logic                w_emit;
    logic                w_err;
    logic                w_ld;

    hex_nibble_decode u_dec (
        .i_char   (in_char),
        .o_is_hex (w_is_hex),
        .o_nib    (w_nib)
    );

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_is_lf    = (in_char == CH_LF);
    assign w_is_cr    = (in_char == CH_CR);
    assign w_is_sp    = (in_char == CH_SP);
    assign w_is_colon = (in_char == CH_COLON);
    assign w_cnt_full = (r_cnt == CNT_MAX);

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_addr   = r_out_addr;
    assign line_done  = r_line_done;
    assign err        = r_err;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_OFS;
        else     r_state <= w_state_nxt;
    end

    // Next-state: newline always resyncs to the offset field, CR is transparent
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            if (w_is_lf) begin
                w_state_nxt = S_OFS;
            end else if (!w_is_cr) begin
                case (r_state)
                    S_OFS: begin
                        if (w_is_hex)
                            w_state_nxt = w_cnt_full ? S_SKIP : S_OFS;
                        else if (w_is_colon && r_cnt != '0)
                            w_state_nxt = S_HEX_HI;
                        else
                            w_state_nxt = S_SKIP;
                    end
                    S_HEX_HI: begin
                        if (w_is_hex)
                            w_state_nxt = S_HEX_LO;
                        else if (w_is_sp)
                            w_state_nxt = (r_spc != 2'd0) ? S_SKIP : S_HEX_HI;
                        else
                            w_state_nxt = S_SKIP;
                    end
                    S_HEX_LO: w_state_nxt = w_is_hex ? S_HEX_HI : S_SKIP;
                    default:  w_state_nxt = S_SKIP;
                endcase
            end
        end
    end

    // Per-character outputs: byte emit, format error, end-of-line
    always_comb begin
        w_emit = 1'b0;
        w_err  = 1'b0;
        w_ld   = w_accept && w_is_lf;
        if (w_accept) begin
            if (w_is_lf) begin
                w_err = (r_state == S_HEX_LO);
            end else if (!w_is_cr) begin
                case (r_state)
                    S_OFS: begin
                        if (w_is_hex)
                            w_err = w_cnt_full;
                        else
                            w_err = !(w_is_colon && r_cnt != '0);
                    end
                    S_HEX_HI: w_err = !w_is_hex && !w_is_sp;
                    S_HEX_LO: begin
                        w_emit = w_is_hex;
                        w_err  = !w_is_hex;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Datapath: offset accumulation, nibble latch, output byte register, pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_spc       <= 2'd0;
            r_hi        <= 4'd0;
            r_line_addr <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'd0;
            r_out_addr  <= '0;
            r_line_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_line_done <= w_ld;
            r_err       <= w_err;

            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_data  <= {r_hi, w_nib};
                r_out_addr  <= r_line_addr;
                r_line_addr <= r_line_addr + 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_accept) begin
                if (w_is_lf) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                    r_spc <= 2'd0;
                end else if (!w_is_cr) begin
                    case (r_state)
                        S_OFS: begin
                            if (w_is_hex && !w_cnt_full) begin
                                r_acc <= {r_acc[ADDR_W-5:0], w_nib};
                                r_cnt <= r_cnt + 1'b1;
                            end else if (w_is_colon && r_cnt != '0) begin
                                r_line_addr <= r_acc;
                                r_spc       <= 2'd0;
                            end
                        end
                        S_HEX_HI: begin
                            if (w_is_hex) begin
                                r_hi  <= w_nib;
                                r_spc <= 2'd0;
                            end else if (w_is_sp) begin
                                r_spc <= r_spc + 2'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_xxd_reverse.sv
module tb_xxd_reverse;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_char;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [31:0] out_addr;
    logic        out_ready;
    logic        line_done;
    logic        err;

    always #5 clk = ~clk;

    xxd_reverse #(.ADDR_W(32), .OFS_DIGITS_MAX(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_char   (in_char),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_ready (out_ready),
        .line_done (line_done),
        .err       (err)
    );

    typedef struct {
        string txt;
        bit    stall;
        int    first;
        int    nb;
        int    ne;
        int    nl;
    } vec_t;

    vec_t        vecs[$];
    vec_t        cur;
    logic [7:0]  exp_d[$];
    logic [31:0] exp_a[$];
    logic [7:0]  got_d[$];
    logic [31:0] got_a[$];
    int          got_ne, got_nl, rdy_viol;
    int          nvec = 0;
    int          nmis = 0;

    task automatic ck(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic mkv(input string t, input bit s, input int ne, input int nl);
        cur.txt   = t;
        cur.stall = s;
        cur.first = exp_d.size();
        cur.nb    = 0;
        cur.ne    = ne;
        cur.nl    = nl;
    endtask

    task automatic addb(input logic [7:0] d, input logic [31:0] a);
        exp_d.push_back(d);
        exp_a.push_back(a);
        cur.nb++;
    endtask

    task automatic endv();
        vecs.push_back(cur);
    endtask

    // Drives one text stream, collecting emitted bytes and pulses; optionally
    // holds out_ready low for 10 cycles once the first byte shows up.
    task automatic run_stream(input string t, input bit stall);
        int idx = 0;
        int cyc = 0;
        int drain = 0;
        int stall_left = 0;
        bit stall_done = 0;
        got_d.delete();
        got_a.delete();
        got_ne = 0;
        got_nl = 0;
        rdy_viol = 0;
        while (drain < 4 && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (stall && !stall_done && out_valid) begin
                stall_left = 10;
                stall_done = 1;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (idx < t.len()) begin
                in_valid = 1'b1;
                in_char  = t[idx];
            end else begin
                in_valid = 1'b0;
                in_char  = 8'h00;
                drain++;
            end
            #1;
            if (out_valid && out_ready) begin
                got_d.push_back(out_data);
                got_a.push_back(out_addr);
            end
            if (err) got_ne++;
            if (line_done) got_nl++;
            if (out_valid && !out_ready && in_ready) rdy_viol++;
            if (in_valid && in_ready) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ck("stream_completed", 64'(drain >= 4), 64'd1);
    endtask

    task automatic apply_vec(input vec_t v, input int k);
        int n;
        run_stream(v.txt, v.stall);
        ck($sformatf("v%0d byte_count", k), 64'(got_d.size()), 64'(v.nb));
        n = (got_d.size() < v.nb) ? got_d.size() : v.nb;
        for (int i = 0; i < n; i++) begin
            ck($sformatf("v%0d data[%0d]", k, i), 64'(got_d[i]), 64'(exp_d[v.first + i]));
            ck($sformatf("v%0d addr[%0d]", k, i), 64'(got_a[i]), 64'(exp_a[v.first + i]));
        end
        ck($sformatf("v%0d err_pulses", k), 64'(got_ne), 64'(v.ne));
        ck($sformatf("v%0d line_done_pulses", k), 64'(got_nl), 64'(v.nl));
        ck($sformatf("v%0d in_ready_while_held", k), 64'(rdy_viol), 64'd0);
    endtask

    initial begin
        string s5;
        int idx;
        int guard;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        out_ready = 1'b1;

        mkv("00000010: 4865 6c6c  Hell\n", 1'b0, 0, 1);
        addb(8'h48, 32'h10); addb(8'h65, 32'h11); addb(8'h6C, 32'h12); addb(8'h6C, 32'h13);
        endv();
        mkv("FFFFFFFE: Ab0102\r\n", 1'b0, 0, 1);
        addb(8'hAB, 32'hFFFF_FFFE); addb(8'h01, 32'hFFFF_FFFF); addb(8'h02, 32'h0000_0000);
        endv();
        mkv("00000010: 4865 6c6c  Hell\n", 1'b1, 0, 1);
        addb(8'h48, 32'h10); addb(8'h65, 32'h11); addb(8'h6C, 32'h12); addb(8'h6C, 32'h13);
        endv();
        mkv("0000000G: 12\n", 1'b0, 1, 1); endv();
        mkv("00000000: 34\n", 1'b0, 0, 1); addb(8'h34, 32'h0); endv();
        mkv("00000000: 1 2\n", 1'b0, 1, 1); endv();
        mkv("123456789: 00\n", 1'b0, 1, 1); endv();
        mkv("00000000: 1\n", 1'b0, 1, 1); endv();
        mkv(": 12\n", 1'b0, 1, 1); endv();
        mkv("1A:FF\n", 1'b0, 0, 1); addb(8'hFF, 32'h1A); endv();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        ck("rst out_valid", 64'(out_valid), 64'd0);
        ck("rst out_data", 64'(out_data), 64'd0);
        ck("rst out_addr", 64'(out_addr), 64'd0);
        ck("rst line_done", 64'(line_done), 64'd0);
        ck("rst err", 64'(err), 64'd0);
        ck("rst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[k]) apply_vec(vecs[k], k);

        // Reset while a byte is held: the pending byte must be dropped
        s5 = "00000020: 41";
        out_ready = 1'b0;
        idx = 0;
        guard = 0;
        while (idx < s5.len() && guard < 200) begin
            @(negedge clk);
            guard++;
            in_valid = 1'b1;
            in_char  = s5[idx];
            #1;
            if (in_ready) idx++;
        end
        ck("held_stream_sent", 64'(idx), 64'(s5.len()));
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        ck("held out_valid", 64'(out_valid), 64'd1);
        ck("held out_data", 64'(out_data), 64'h41);
        ck("held out_addr", 64'(out_addr), 64'h20);
        ck("held in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        ck("mid_rst out_valid", 64'(out_valid), 64'd0);
        ck("mid_rst out_data", 64'(out_data), 64'd0);
        ck("mid_rst out_addr", 64'(out_addr), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        mkv("00000000: 42\n", 1'b0, 0, 1); addb(8'h42, 32'h0); endv();
        apply_vec(cur, 99);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
